// File: rtl/matrix_keypad_scanner.sv
// matrix_keypad_scanner
//
// Scans a ROWS x COLS active-low key matrix once per scan tick, debounces
// press and release, flags long presses and queues key events in a small
// FIFO with a valid/ready handshake.
//
// The row pins are sampled directly on the scan tick, so they are expected
// to reach this block through the board pad synchroniser.
//
// Ports:
//   i_clk      system clock
//   i_rst_n    asynchronous active-low reset
//   row        matrix rows, active-low, externally pulled up
//   col        matrix column drive, active-low (all low while idle)
//   key_code   code of the FIFO head entry (col_index*ROWS + row_index)
//   key_long   head entry is a long-press event
//   key_valid  FIFO non-empty
//   key_ready  consumer accepts the head entry
//   key_down   a debounced key is currently held
//   overflow   one-cycle pulse when an event is dropped on a full FIFO
//   fifo_count number of queued entries
module matrix_keypad_scanner #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 1048576,
  parameter int DEBOUNCE   = 2,
  parameter int HOLD_TICKS = 50,
  parameter int FIFO_DEPTH = 4,
  parameter int CW         = $clog2(ROWS*COLS)
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [ROWS-1:0]               row,
  output logic [COLS-1:0]               col,
  output logic [CW-1:0]                 key_code,
  output logic                          key_long,
  output logic                          key_valid,
  input  logic                          key_ready,
  output logic                          key_down,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIVW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CIW  = $clog2(COLS);
  localparam int RIW  = $clog2(ROWS);
  localparam int DW   = $clog2(DEBOUNCE + 1);
  localparam int HW   = $clog2(HOLD_TICKS + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = AW + 1;
  localparam int EW   = CW + 1;

  typedef enum logic [2:0] {IDLE, SCAN, CONFIRM, HELD, RELEASE} state_t;

  state_t          state_q, state_d;
  logic [DIVW-1:0] div_q, div_d;
  logic [COLS-1:0] col_q, col_d;
  logic [CIW-1:0]  col_idx_q, col_idx_d;
  logic [CW-1:0]   code_q, code_d;
  logic [DW-1:0]   deb_q, deb_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            long_done_q, long_done_d;
  logic            key_down_q, key_down_d;
  logic            overflow_q, overflow_d;
  logic [EW-1:0]   mem_q [FIFO_DEPTH];
  logic [EW-1:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;

  logic            tick;
  logic            row_hit;
  logic            same_code;
  logic [RIW-1:0]  row_idx;
  logic [CW-1:0]   cur_code;
  logic [DW-1:0]   deb_inc;
  logic [HW-1:0]   hold_inc;
  logic            push;
  logic            push_long;
  logic            pop;
  logic            full;
  logic            push_ok;

  assign tick      = (div_q == DIVW'(SCAN_DIV - 1));
  assign row_hit   = ~&row;
  assign cur_code  = CW'(int'(col_idx_q) * ROWS + int'(row_idx));
  assign same_code = row_hit && (cur_code == code_q);
  assign deb_inc   = deb_q + DW'(1);
  assign hold_inc  = hold_q + HW'(1);

  // Lowest low row wins when several keys share the scanned column.
  always_comb begin
    row_idx = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!row[i]) row_idx = RIW'(i);
    end
  end

  // Scan/debounce state machine; everything here moves only on a tick.
  // deb_q is zero whenever HELD is active, so the HELD->RELEASE step
  // counts the first released tick with the same adder as RELEASE does.
  always_comb begin
    state_d     = state_q;
    div_d       = tick ? '0 : div_q + DIVW'(1);
    col_d       = col_q;
    col_idx_d   = col_idx_q;
    code_d      = code_q;
    deb_d       = deb_q;
    hold_d      = hold_q;
    long_done_d = long_done_q;
    key_down_d  = key_down_q;
    push        = 1'b0;
    push_long   = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE: begin
          col_d = '0;
          if (row_hit) begin
            state_d   = SCAN;
            col_d     = ~COLS'(1);
            col_idx_d = '0;
          end
        end
        SCAN: begin
          if (row_hit) begin
            code_d  = cur_code;
            deb_d   = '0;
            state_d = CONFIRM;
          end else if (col_idx_q == CIW'(COLS - 1)) begin
            state_d   = IDLE;
            col_d     = '0;
            col_idx_d = '0;
          end else begin
            col_idx_d = col_idx_q + CIW'(1);
            col_d     = ~(COLS'(1) << (col_idx_q + CIW'(1)));
          end
        end
        CONFIRM: begin
          if (same_code) begin
            deb_d = deb_inc;
            if (deb_inc == DW'(DEBOUNCE)) begin
              push        = 1'b1;
              deb_d       = '0;
              hold_d      = '0;
              long_done_d = 1'b0;
              key_down_d  = 1'b1;
              state_d     = HELD;
            end
          end else begin
            state_d   = IDLE;
            col_d     = '0;
            col_idx_d = '0;
            deb_d     = '0;
          end
        end
        HELD: begin
          if (!row_hit) begin
            deb_d   = deb_inc;
            state_d = RELEASE;
            if (deb_inc == DW'(DEBOUNCE)) begin
              state_d    = IDLE;
              key_down_d = 1'b0;
              col_d      = '0;
              col_idx_d  = '0;
              deb_d      = '0;
            end
          end else if (same_code && !long_done_q) begin
            hold_d = hold_inc;
            if (hold_inc == HW'(HOLD_TICKS)) begin
              push        = 1'b1;
              push_long   = 1'b1;
              long_done_d = 1'b1;
            end
          end
        end
        RELEASE: begin
          if (!row_hit) begin
            deb_d = deb_inc;
            if (deb_inc == DW'(DEBOUNCE)) begin
              state_d    = IDLE;
              key_down_d = 1'b0;
              col_d      = '0;
              col_idx_d  = '0;
              deb_d      = '0;
            end
          end else if (same_code) begin
            // Contact bounce on release: resume without a new event.
            state_d = HELD;
            deb_d   = '0;
          end else begin
            state_d    = IDLE;
            key_down_d = 1'b0;
            col_d      = '0;
            col_idx_d  = '0;
            deb_d      = '0;
          end
        end
        default: begin
          state_d = IDLE;
          col_d   = '0;
        end
      endcase
    end
  end

  // Event FIFO. A full FIFO still accepts a push when the head is popped
  // in the same cycle; otherwise the event is dropped and flagged.
  always_comb begin
    pop        = key_valid && key_ready;
    full       = (count_q == CNTW'(FIFO_DEPTH));
    push_ok    = push && (!full || pop);
    overflow_d = push && full && !pop;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = {push_long, code_q};
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      div_q       <= '0;
      col_q       <= '0;
      col_idx_q   <= '0;
      code_q      <= '0;
      deb_q       <= '0;
      hold_q      <= '0;
      long_done_q <= 1'b0;
      key_down_q  <= 1'b0;
      overflow_q  <= 1'b0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      col_q       <= col_d;
      col_idx_q   <= col_idx_d;
      code_q      <= code_d;
      deb_q       <= deb_d;
      hold_q      <= hold_d;
      long_done_q <= long_done_d;
      key_down_q  <= key_down_d;
      overflow_q  <= overflow_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  assign col        = col_q;
  assign key_down   = key_down_q;
  assign overflow   = overflow_q;
  assign fifo_count = count_q;
  assign key_valid  = (count_q != '0);
  assign key_code   = mem_q[rd_ptr_q][CW-1:0];
  assign key_long   = mem_q[rd_ptr_q][CW];

endmodule

// File: tb/tb_matrix_keypad_scanner.sv
// tb_matrix_keypad_scanner
//
// Drives a behavioural key matrix (pressed keys pull their row low while
// their column is driven low) and checks the event stream through a
// scoreboard queue: expected events are queued when a press is applied and
// compared when the DUT hands them over on key_valid && key_ready.
module tb_matrix_keypad_scanner;

  localparam int ROWS       = 4;
  localparam int COLS       = 4;
  localparam int SCAN_DIV   = 4;
  localparam int DEBOUNCE   = 2;
  localparam int HOLD_TICKS = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int CW         = $clog2(ROWS*COLS);
  localparam int FCW        = $clog2(FIFO_DEPTH) + 1;
  localparam int KW         = ROWS*COLS;
  localparam int WAIT_BUDGET = 64*SCAN_DIV;

  logic            i_clk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic [ROWS-1:0] row;
  logic [COLS-1:0] col;
  logic [CW-1:0]   key_code;
  logic            key_long;
  logic            key_valid;
  logic            key_ready;
  logic            key_down;
  logic            overflow;
  logic [FCW-1:0]  fifo_count;

  logic [KW-1:0]   pressed;

  typedef struct packed {
    logic          lng;
    logic [CW-1:0] code;
  } ev_t;

  ev_t sb[$];
  ev_t mon_ev;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ovf_seen = 0;
  int last_short_cyc = -1000;
  int last_long_cyc = -1000;
  bit kd_seen = 1'b0;

  matrix_keypad_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE),
    .HOLD_TICKS(HOLD_TICKS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .row(row), .col(col),
    .key_code(key_code), .key_long(key_long), .key_valid(key_valid),
    .key_ready(key_ready), .key_down(key_down), .overflow(overflow),
    .fifo_count(fifo_count)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Key matrix model.
  always_comb begin
    row = '1;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        if (pressed[c*ROWS + r] && !col[c]) row[r] = 1'b0;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
    end
  endtask

  function automatic ev_t mkEv(input logic lng, input int code);
    mkEv.lng  = lng;
    mkEv.code = CW'(code);
  endfunction

  // Output side of the scoreboard, sampled on the falling edge.
  always @(negedge i_clk) begin
    if (overflow) ovf_seen++;
    if (key_down) kd_seen = 1'b1;
    if (key_valid && key_ready) begin
      checkOutput("pop_expected_pending", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_ev = sb.pop_front();
        checkOutput("pop_code", 32'(key_code), 32'(mon_ev.code));
        checkOutput("pop_long", 32'(key_long), 32'(mon_ev.lng));
        if (key_long) last_long_cyc = cyc;
        else          last_short_cyc = cyc;
      end
    end
  end

  task automatic waitKeyDown(input logic level, input string tag, output int at_cyc);
    for (int i = 0; i < WAIT_BUDGET; i++) begin
      @(posedge i_clk); #1;
      if (key_down == level) break;
    end
    at_cyc = cyc;
    checkOutput(tag, 32'(key_down), 32'(level));
  endtask

  task automatic waitDrain(input string tag);
    for (int i = 0; i < 16*SCAN_DIV; i++) begin
      @(negedge i_clk);
      if (sb.size() == 0 && !key_valid) break;
    end
    @(posedge i_clk); #1;
    checkOutput({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    checkOutput({tag, "_valid_low"}, 32'(key_valid), 32'd0);
  endtask

  // One short press of the given key set, released once key_down rises.
  task automatic applyStimulus(input logic [KW-1:0] keys, input int code,
                               input bit expect_push);
    int t;
    pressed = keys;
    if (expect_push) sb.push_back(mkEv(1'b0, code));
    waitKeyDown(1'b1, $sformatf("stim%0d_down", code), t);
    pressed = '0;
    waitKeyDown(1'b0, $sformatf("stim%0d_up", code), t);
    repeat (2*SCAN_DIV) @(posedge i_clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL global_timeout: got running, want finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int t_press, t_down, t_rel, t_fall, t_rr, ovf0;
    pressed   = '0;
    key_ready = 1'b0;
    i_rst_n   = 1'b0;
    repeat (3) @(posedge i_clk);
    #1;
    checkOutput("rst_col", 32'(col), 32'd0);
    checkOutput("rst_key_code", 32'(key_code), 32'd0);
    checkOutput("rst_key_long", 32'(key_long), 32'd0);
    checkOutput("rst_key_valid", 32'(key_valid), 32'd0);
    checkOutput("rst_key_down", 32'(key_down), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_fifo_count", 32'(fifo_count), 32'd0);
    @(negedge i_clk) i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // 1: col2/row1 held for 20 ticks -> short 9 then long 9.
    $display("[TB] scenario 1: long press of code 9");
    key_ready = 1'b1;
    sb.push_back(mkEv(1'b0, 9));
    sb.push_back(mkEv(1'b1, 9));
    t_press = cyc;
    pressed[9] = 1'b1;
    waitKeyDown(1'b1, "t1_down_rise", t_down);
    $display("[TB] t1 press latency %0d cycles", t_down - t_press);
    checkOutput("t1_press_latency_in_21_24",
                32'((t_down - t_press) >= 5*SCAN_DIV+1 && (t_down - t_press) <= 6*SCAN_DIV), 32'd1);
    repeat (20*SCAN_DIV) @(posedge i_clk);
    #1;
    checkOutput("t1_short_with_key_down", 32'(last_short_cyc), 32'(t_down));
    checkOutput("t1_long_delay", 32'(last_long_cyc - t_down), 32'(HOLD_TICKS*SCAN_DIV));
    checkOutput("t1_key_down_held", 32'(key_down), 32'd1);
    t_rel = cyc;
    pressed[9] = 1'b0;
    waitKeyDown(1'b0, "t1_down_fall", t_fall);
    $display("[TB] t1 release latency %0d cycles", t_fall - t_rel);
    checkOutput("t1_release_latency_in_5_8",
                32'((t_fall - t_rel) >= 2*SCAN_DIV-3 && (t_fall - t_rel) <= 2*SCAN_DIV), 32'd1);
    waitDrain("t1");

    // 2: one-tick bounce on row0 -> nothing.
    $display("[TB] scenario 2: bounce");
    repeat (2*SCAN_DIV) @(posedge i_clk);
    #1;
    kd_seen = 1'b0;
    pressed[0] = 1'b1;
    repeat (SCAN_DIV) @(posedge i_clk);
    #1;
    pressed[0] = 1'b0;
    repeat (8*SCAN_DIV) @(posedge i_clk);
    #1;
    checkOutput("t2_key_down_never", 32'(kd_seen), 32'd0);
    checkOutput("t2_valid_low", 32'(key_valid), 32'd0);
    checkOutput("t2_idle_col", 32'(col), 32'd0);
    checkOutput("t2_fifo_empty", 32'(fifo_count), 32'd0);

    // 3: five presses with the consumer stalled -> one overflow.
    $display("[TB] scenario 3: overflow");
    key_ready = 1'b0;
    ovf0 = ovf_seen;
    for (int k = 0; k < 5; k++) applyStimulus(KW'(1) << k, k, k < 4);
    checkOutput("t3_fifo_full", 32'(fifo_count), 32'd4);
    checkOutput("t3_valid_high", 32'(key_valid), 32'd1);
    checkOutput("t3_overflow_once", 32'(ovf_seen - ovf0), 32'd1);
    key_ready = 1'b1;
    waitDrain("t3");
    checkOutput("t3_fifo_count_zero", 32'(fifo_count), 32'd0);

    // 4: rows 0 and 2 in col3 -> only code 12.
    $display("[TB] scenario 4: two rows in one column");
    applyStimulus((KW'(1) << 12) | (KW'(1) << 14), 12, 1'b1);
    waitDrain("t4");

    // 5: reset while HELD with two entries queued.
    $display("[TB] scenario 5: reset mid-hold");
    key_ready = 1'b0;
    pressed = KW'(1) << 5;
    waitKeyDown(1'b1, "t5_down_rise", t_down);
    for (int i = 0; i < 20*SCAN_DIV; i++) begin
      if (fifo_count == FCW'(2)) break;
      @(posedge i_clk); #1;
    end
    checkOutput("t5_two_queued", 32'(fifo_count), 32'd2);
    #2 i_rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_col", 32'(col), 32'd0);
    checkOutput("t5_rst_fifo_count", 32'(fifo_count), 32'd0);
    checkOutput("t5_rst_valid", 32'(key_valid), 32'd0);
    checkOutput("t5_rst_key_down", 32'(key_down), 32'd0);
    sb.delete();
    key_ready = 1'b1;
    sb.push_back(mkEv(1'b0, 5));
    repeat (2) @(posedge i_clk);
    @(negedge i_clk) i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    t_rr = cyc;
    waitKeyDown(1'b1, "t5_repress_down", t_down);
    checkOutput("t5_repress_latency_in_12_29",
                32'((t_down - t_rr) >= (1+DEBOUNCE)*SCAN_DIV &&
                    (t_down - t_rr) <= (1+COLS+DEBOUNCE)*SCAN_DIV+1), 32'd1);
    pressed = '0;
    waitKeyDown(1'b0, "t5_repress_up", t_fall);
    waitDrain("t5");

    // 6: full FIFO, pop coincides with the long-press push.
    $display("[TB] scenario 6: push and pop while full");
    key_ready = 1'b0;
    for (int k = 6; k < 9; k++) applyStimulus(KW'(1) << k, k, 1'b1);
    sb.push_back(mkEv(1'b0, 10));
    sb.push_back(mkEv(1'b1, 10));
    pressed = KW'(1) << 10;
    waitKeyDown(1'b1, "t6_down_rise", t_down);
    checkOutput("t6_full", 32'(fifo_count), 32'd4);
    ovf0 = ovf_seen;
    repeat (HOLD_TICKS*SCAN_DIV - 1) @(posedge i_clk);
    #1 key_ready = 1'b1;
    @(posedge i_clk);
    #1 key_ready = 1'b0;
    @(negedge i_clk);
    checkOutput("t6_no_overflow_pulse", 32'(overflow), 32'd0);
    checkOutput("t6_count_unchanged", 32'(fifo_count), 32'd4);
    @(posedge i_clk); #1;
    checkOutput("t6_overflow_count", 32'(ovf_seen - ovf0), 32'd0);
    pressed = '0;
    waitKeyDown(1'b0, "t6_down_fall", t_fall);
    key_ready = 1'b1;
    waitDrain("t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
